// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD-RLS systolic array cells: word format,
// the unity constant, cell state encoding and saturation bounds.
package qrd_pkg;

    localparam int DATA_LENGTH_DEF = 16;
    localparam int FRAC_BITS_DEF   = 14;
    localparam int ONE             = 1 << FRAC_BITS_DEF;

    localparam logic signed [DATA_LENGTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_LENGTH_DEF-1){1'b1}}};
    localparam logic signed [DATA_LENGTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_LENGTH_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HAVE_ROT = 3'd1,
        HAVE_X   = 3'd2,
        MUL      = 3'd3,
        ACC      = 3'd4,
        HOLD     = 3'd5
    } cell_state_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-up, drop FRAC fraction bits and clamp to OUT_W signed; flags clamping.
// Purely combinational (0 cycles); no flow control.
module fxp_round_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int FRAC  = 14
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam int SH_W  = EXT_W - FRAC;

    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (FRAC - 1);
    localparam logic signed [SH_W-1:0]  HI   = {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0]  LO   = {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] rounded;
    logic signed [SH_W-1:0]  shifted;

    always_comb begin
        rounded = {din[IN_W-1], din} + HALF;
        shifted = rounded[EXT_W-1:FRAC];
        sat     = 1'b0;
        dout    = shifted[OUT_W-1:0];
        if (shifted > HI) begin
            dout = HI[OUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < LO) begin
            dout = LO[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/internal_cell.sv
// QRD-RLS internal cell: applies rotation (c,s) to stored r and incoming x.
// out_valid 2 edges after capture completes; holds results while out_ready low.
module internal_cell
    import qrd_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [DATA_LENGTH-1:0] cos_in,
    input  logic [DATA_LENGTH-1:0] sine_in,
    input  logic                   rot_valid,
    output logic                   rot_ready,
    input  logic [DATA_LENGTH-1:0] x_in,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [DATA_LENGTH-1:0] x_out,
    output logic [DATA_LENGTH-1:0] cos_out,
    output logic [DATA_LENGTH-1:0] sine_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] r_out,
    output logic                   overflow
);

    localparam int W  = DATA_LENGTH;
    localparam int PW = 2 * DATA_LENGTH;
    localparam int SW = 2 * DATA_LENGTH + 1;

    cell_state_t state, state_nxt;

    logic signed [W-1:0]  c_q, s_q, x_q, r_q;
    logic signed [PW-1:0] p_cx, p_sr, p_sx, p_cr;
    logic signed [SW-1:0] sum_x, sum_r;
    logic signed [W-1:0]  x_new, r_new;
    logic                 sat_x, sat_r;
    logic                 rot_fire, x_fire;

    assign rot_ready = rst && (state == IDLE || state == HAVE_X);
    assign x_ready   = rst && (state == IDLE || state == HAVE_ROT);
    assign rot_fire  = rot_valid && rot_ready;
    assign x_fire    = x_valid && x_ready;
    assign r_out     = r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rot_fire && x_fire) state_nxt = MUL;
                else if (rot_fire)      state_nxt = HAVE_ROT;
                else if (x_fire)        state_nxt = HAVE_X;
            end
            HAVE_ROT: if (x_fire)   state_nxt = MUL;
            HAVE_X:   if (rot_fire) state_nxt = MUL;
            MUL:      state_nxt = ACC;
            ACC:      state_nxt = HOLD;
            HOLD:     if (out_valid && out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Sums carry one extra bit so the difference/sum of two full products cannot wrap.
    assign sum_x = {p_cx[PW-1], p_cx} - {p_sr[PW-1], p_sr};
    assign sum_r = {p_sx[PW-1], p_sx} + {p_cr[PW-1], p_cr};

    fxp_round_sat #(.IN_W(SW), .OUT_W(W), .FRAC(FRAC_BITS)) u_rs_x (
        .din  (sum_x),
        .dout (x_new),
        .sat  (sat_x)
    );

    fxp_round_sat #(.IN_W(SW), .OUT_W(W), .FRAC(FRAC_BITS)) u_rs_r (
        .din  (sum_r),
        .dout (r_new),
        .sat  (sat_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q       <= '0;
            s_q       <= '0;
            x_q       <= '0;
            r_q       <= '0;
            p_cx      <= '0;
            p_sr      <= '0;
            p_sx      <= '0;
            p_cr      <= '0;
            x_out     <= '0;
            cos_out   <= '0;
            sine_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (rot_fire) begin
                c_q <= cos_in;
                s_q <= sine_in;
            end
            if (x_fire) x_q <= x_in;
            // r is only read in MUL, so a clear on the capture edge is seen by that rotation.
            if (state == IDLE && clear) r_q <= '0;
            if (state == MUL) begin
                p_cx <= PW'(c_q) * PW'(x_q);
                p_sr <= PW'(s_q) * PW'(r_q);
                p_sx <= PW'(s_q) * PW'(x_q);
                p_cr <= PW'(c_q) * PW'(r_q);
            end
            if (state == ACC) begin
                r_q       <= r_new;
                x_out     <= x_new;
                cos_out   <= c_q;
                sine_out  <= s_q;
                out_valid <= 1'b1;
                overflow  <= sat_x | sat_r;
            end
            if (state == HOLD && out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_internal_cell.sv
// Directed vector bench for internal_cell: table of rotations plus split-arrival,
// backpressure and mid-operation reset sequences.
module tb_internal_cell;
    import qrd_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic [W-1:0] cos_in, sine_in, x_in;
    logic         rot_valid, x_valid, out_ready;
    logic         rot_ready, x_ready, out_valid, overflow;
    logic [W-1:0] x_out, cos_out, sine_out, r_out;

    internal_cell #(.DATA_LENGTH(W), .FRAC_BITS(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cos_in    (cos_in),
        .sine_in   (sine_in),
        .rot_valid (rot_valid),
        .rot_ready (rot_ready),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_out     (x_out),
        .cos_out   (cos_out),
        .sine_out  (sine_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic clr;
        int   c;
        int   s;
        int   x;
        int   ex;
        int   er;
        logic eo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(rot_ready && x_ready) && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_idle_wait"}, 32'(rot_ready && x_ready), 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        wait_idle(name);
        cos_in    = 16'(v.c);
        sine_in   = 16'(v.s);
        x_in      = 16'(v.x);
        clear     = v.clr;
        rot_valid = 1'b1;
        x_valid   = 1'b1;
        tick();
        rot_valid = 1'b0;
        x_valid   = 1'b0;
        clear     = 1'b0;
        chk({name, "_busy_rdy"}, 32'(rot_ready | x_ready), 0);
        tick();
        chk({name, "_valid_e1"}, 32'(out_valid), 0);
        tick();
        chk({name, "_valid_e2"}, 32'(out_valid), 1);
        chk({name, "_x_out"}, $signed(x_out), v.ex);
        chk({name, "_r_out"}, $signed(r_out), v.er);
        chk({name, "_cos_out"}, $signed(cos_out), v.c);
        chk({name, "_sine_out"}, $signed(sine_out), v.s);
        chk({name, "_overflow"}, 32'(overflow), 32'(v.eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'(out_valid), 0);
        chk({name, "_ovf_drop"}, 32'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t t;
        int   bad;

        //           clr   c       s      x       x_out  r_out   ovf
        vecs[0] = '{1'b0, ONE,    0,     8192,   8192,  0,      1'b0}; // identity
        vecs[1] = '{1'b0, 0,      ONE,   8192,   0,     8192,   1'b0}; // full swap
        vecs[2] = '{1'b0, 11585,  11585, 8192,   0,     11585,  1'b0}; // 45 degrees
        vecs[3] = '{1'b1, ONE,    ONE,   24576,  24576, 24576,  1'b0}; // clear on capture edge
        vecs[4] = '{1'b0, ONE,    ONE,   24576,  0,     32767,  1'b1}; // positive saturation
        vecs[5] = '{1'b0, ONE,    0,     -5,     -5,    32767,  1'b0}; // identity at r max
        vecs[6] = '{1'b0, -ONE,   ONE,   -32768, 1,     -32768, 1'b1}; // negative saturation
        vecs[7] = '{1'b1, 3,      0,     8192,   2,     0,      1'b0}; // +1.5 rounds to 2
        vecs[8] = '{1'b0, -3,     0,     8192,   -1,    0,      1'b0}; // -1.5 rounds to -1

        rst       = 1'b0;
        clear     = 1'b0;
        cos_in    = '0;
        sine_in   = '0;
        x_in      = '0;
        rot_valid = 1'b0;
        x_valid   = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        chk("rst_x_out", $signed(x_out), 0);
        chk("rst_r_out", $signed(r_out), 0);
        chk("rst_cos_out", $signed(cos_out), 0);
        chk("rst_sine_out", $signed(sine_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_rot_ready", 32'(rot_ready), 0);
        chk("rst_x_ready", 32'(x_ready), 0);
        rst = 1'b1;
        #1;
        chk("idle_rot_ready", 32'(rot_ready), 1);
        chk("idle_x_ready", 32'(x_ready), 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Split arrival: rotation captured on edge 0, sample on edge 3.
        wait_idle("split");
        cos_in    = 16'(ONE);
        sine_in   = '0;
        rot_valid = 1'b1;
        tick();
        rot_valid = 1'b0;
        chk("split_have_rot_rot_rdy", 32'(rot_ready), 0);
        chk("split_have_rot_x_rdy", 32'(x_ready), 1);
        tick();
        tick();
        chk("split_still_waiting", 32'(out_valid), 0);
        x_in    = 16'd100;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        chk("split_valid_e1_pre", 32'(out_valid), 0);
        tick();
        chk("split_valid_e1", 32'(out_valid), 0);
        tick();
        chk("split_valid_e2", 32'(out_valid), 1);
        chk("split_x_out", $signed(x_out), 100);
        chk("split_r_out", $signed(r_out), 0);

        // Backpressure: offer new inputs that must not be taken while held.
        bad       = 0;
        rot_valid = 1'b1;
        x_valid   = 1'b1;
        cos_in    = 16'd7;
        x_in      = 16'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || x_out !== 16'd100 || cos_out !== 16'(ONE)
                || rot_ready !== 1'b0 || x_ready !== 1'b0)
                bad++;
        end
        rot_valid = 1'b0;
        x_valid   = 1'b0;
        chk("hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 0);
        chk("release_rot_ready", 32'(rot_ready), 1);
        chk("release_x_ready", 32'(x_ready), 1);

        // Build a non-zero r, then abort a rotation with reset during MUL.
        t = '{1'b0, 0, ONE, 8192, 0, 8192, 1'b0};
        run_vec(t, "pre_abort");
        wait_idle("abort");
        cos_in    = 16'(ONE);
        sine_in   = 16'(ONE);
        x_in      = 16'd100;
        rot_valid = 1'b1;
        x_valid   = 1'b1;
        tick();
        rot_valid = 1'b0;
        x_valid   = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("abort_r_out", $signed(r_out), 0);
        chk("abort_x_out", $signed(x_out), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_rot_ready", 32'(rot_ready), 0);
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0 || r_out !== '0) bad++;
        end
        chk("abort_no_output", bad, 0);
        chk("abort_idle_ready", 32'(rot_ready && x_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
